// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage MIPS pipeline.
// It covers Tuse/Tnew data hazards, mult/div occupancy, the eret-vs-mtc0 EPC hazard and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_is_md,
  input  logic             D_eret,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  input  logic             E_mtc0_epc,
  input  logic             M_mtc0_epc,
  input  logic             exc_req,
  output logic             stall,
  output logic             en_F,
  output logic             en_D,
  output logic             req,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // Reload values count the cycles left after the issue cycle; latencies must lie in 1..16.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

  md_state_t        r_md_state;
  logic [3:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [4:0] w_src  [2];
  logic [1:0] w_tuse [2];
  logic [1:0] w_src_stall;
  logic       w_md_issue;
  logic [3:0] w_md_load;
  logic       w_md_busy;
  logic       w_stall_md;
  logic       w_stall_eret;
  logic       w_raw_stall;
  logic       w_stall;

  assign w_src[0]  = D_rs;
  assign w_src[1]  = D_rt;
  assign w_tuse[0] = D_tuse_rs;
  assign w_tuse[1] = D_tuse_rt;

  // Tuse of 3 can never be exceeded by a 2-bit Tnew, so unused operands drop out naturally.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_hazard
      assign w_src_stall[gi] = (w_src[gi] != 5'd0) &&
                               (((E_wa == w_src[gi]) && (E_tnew > w_tuse[gi])) ||
                                ((M_wa == w_src[gi]) && (M_tnew > w_tuse[gi])));
    end
  endgenerate

  assign w_md_issue   = E_md_start & ~exc_req;
  assign w_md_load    = E_md_is_div ? DIV_LOAD : MULT_LOAD;
  assign w_md_busy    = ~reset & ((r_md_state == MD_BUSY) | w_md_issue);
  assign w_stall_md   = D_is_md & w_md_busy;
  assign w_stall_eret = D_eret & (E_mtc0_epc | M_mtc0_epc);
  assign w_raw_stall  = w_src_stall[0] | w_src_stall[1] | w_stall_md | w_stall_eret;
  assign w_stall      = w_raw_stall & ~exc_req & ~reset;

  assign stall     = w_stall;
  assign en_F      = ~w_stall;
  assign en_D      = ~w_stall;
  assign req       = exc_req & ~reset;
  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_state  <= MD_IDLE;
      r_md_cnt    <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      case (r_md_state)
        MD_IDLE: begin
          if (w_md_issue && (w_md_load != 4'd0)) begin
            r_md_state <= MD_BUSY;
            r_md_cnt   <= w_md_load;
          end
        end
        MD_BUSY: begin
          // Leaving as the count reaches zero keeps occupancy at exactly LAT cycles.
          if (r_md_cnt <= 4'd1) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= 4'd0;
          end else begin
            r_md_cnt <= r_md_cnt - 4'd1;
          end
        end
        default: begin
          r_md_state <= MD_IDLE;
          r_md_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, D_eret, E_md_start, E_md_is_div, E_mtc0_epc, M_mtc0_epc, exc_req;
  logic        stall, en_F, en_D, req, md_busy;
  logic [31:0] stall_cnt;
  logic        stall4, en_F4, en_D4, req4, md_busy4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .D_eret(D_eret), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc),
    .exc_req(exc_req), .stall(stall), .en_F(en_F), .en_D(en_D), .req(req), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .D_eret(D_eret), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc),
    .exc_req(exc_req), .stall(stall4), .en_F(en_F4), .en_D(en_D4), .req(req4), .md_busy(md_busy4),
    .stall_cnt(stall_cnt4)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        req;
    logic        busy;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] exp_cnt = 32'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string txn, input string fld, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", txn, fld, act, req_v);
    end
  endtask

  // Expected stall_cnt is the number of expected stalls in earlier cycles, cleared by a taken reset.
  task automatic issue(input string nm, input logic s, input logic r, input logic b);
    exp_t e;
    e.name  = nm;
    e.stall = s;
    e.req   = r;
    e.busy  = b;
    e.cnt   = exp_cnt;
    e.cnt4  = (exp_cnt > 32'd15) ? 4'hF : exp_cnt[3:0];
    q.push_back(e);
    if (reset) exp_cnt = 32'd0;
    else if (s && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic clr();
    reset = 1'b0; D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    D_is_md = 1'b0; D_eret = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0; E_mtc0_epc = 1'b0; M_mtc0_epc = 1'b0; exc_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk(m_e.name, "stall", {31'd0, stall}, {31'd0, m_e.stall});
      chk(m_e.name, "en_F", {31'd0, en_F}, {31'd0, ~m_e.stall});
      chk(m_e.name, "en_D", {31'd0, en_D}, {31'd0, ~m_e.stall});
      chk(m_e.name, "req", {31'd0, req}, {31'd0, m_e.req});
      chk(m_e.name, "md_busy", {31'd0, md_busy}, {31'd0, m_e.busy});
      chk(m_e.name, "stall_cnt", stall_cnt, m_e.cnt);
      chk(m_e.name, "stall_cnt4", {28'd0, stall_cnt4}, {28'd0, m_e.cnt4});
      chk(m_e.name, "stall4", {31'd0, stall4}, {31'd0, m_e.stall});
      $display("txn %-12s stall=%0b req=%0b busy=%0b cnt=%0d cnt4=%0d", m_e.name, stall, req, md_busy,
               stall_cnt, stall_cnt4);
    end
  end

  initial begin
    clr();
    reset = 1'b1;
    // Reset with every hazard source active: outputs must stay quiet.
    step(); reset = 1'b1; E_wa = 5'd5; E_tnew = 2'd2; D_rs = 5'd5; D_tuse_rs = 2'd0;
    D_is_md = 1'b1; E_md_start = 1'b1; exc_req = 1'b1; D_eret = 1'b1; E_mtc0_epc = 1'b1;
    issue("rst_gate", 0, 0, 0);
    step(); reset = 1'b1; issue("rst_idle", 0, 0, 0);

    // mult: busy t..t+4
    step(); E_md_start = 1'b1; D_is_md = 1'b1; issue("mult_t0", 1, 0, 1);
    for (int i = 1; i < 5; i++) begin
      step(); D_is_md = 1'b1; issue("mult_busy", 1, 0, 1);
    end
    step(); D_is_md = 1'b1; issue("mult_done", 0, 0, 0);

    // div: busy t..t+9
    step(); E_md_start = 1'b1; E_md_is_div = 1'b1; D_is_md = 1'b1; issue("div_t0", 1, 0, 1);
    for (int i = 1; i < 10; i++) begin
      step(); D_is_md = 1'b1; issue("div_busy", 1, 0, 1);
    end
    step(); D_is_md = 1'b1; issue("div_done", 0, 0, 0);

    // Load-use via E then M
    step(); E_wa = 5'd5; E_tnew = 2'd2; D_rs = 5'd5; D_tuse_rs = 2'd0; issue("lu_E", 1, 0, 0);
    step(); M_wa = 5'd5; M_tnew = 2'd1; D_rs = 5'd5; D_tuse_rs = 2'd0; issue("lu_M", 1, 0, 0);
    step(); M_wa = 5'd5; M_tnew = 2'd0; D_rs = 5'd5; D_tuse_rs = 2'd0; issue("lu_clear", 0, 0, 0);
    // rt: Tnew equal to Tuse is no hazard, one more is
    step(); E_wa = 5'd7; E_tnew = 2'd1; D_rt = 5'd7; D_tuse_rt = 2'd1; issue("rt_eq", 0, 0, 0);
    step(); E_wa = 5'd7; E_tnew = 2'd2; D_rt = 5'd7; D_tuse_rt = 2'd1; issue("rt_gt", 1, 0, 0);
    step(); M_wa = 5'd9; M_tnew = 2'd2; D_rt = 5'd9; D_tuse_rt = 2'd0; issue("rt_M", 1, 0, 0);
    // $0 and unused operands
    step(); E_wa = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd0; issue("zero_reg", 0, 0, 0);
    step(); E_wa = 5'd5; E_tnew = 2'd3; D_rs = 5'd5; D_tuse_rs = 2'd3; issue("tuse3", 0, 0, 0);

    // Exception coincident with start: flushed, FSM stays idle
    step(); E_md_start = 1'b1; exc_req = 1'b1; D_is_md = 1'b1; issue("exc_start", 0, 1, 0);
    step(); D_is_md = 1'b1; issue("exc_idle", 0, 0, 0);
    // Exception during BUSY: count continues
    step(); E_md_start = 1'b1; D_is_md = 1'b1; issue("mexc_t0", 1, 0, 1);
    step(); exc_req = 1'b1; D_is_md = 1'b1; issue("mexc_exc", 0, 1, 1);
    for (int i = 2; i < 5; i++) begin
      step(); D_is_md = 1'b1; issue("mexc_busy", 1, 0, 1);
    end
    step(); D_is_md = 1'b1; issue("mexc_done", 0, 0, 0);

    // eret vs mtc0 EPC
    step(); D_eret = 1'b1; E_mtc0_epc = 1'b1; issue("eret_E", 1, 0, 0);
    step(); D_eret = 1'b1; M_mtc0_epc = 1'b1; issue("eret_M", 1, 0, 0);
    step(); D_eret = 1'b1; issue("eret_none", 0, 0, 0);
    step(); D_eret = 1'b1; E_mtc0_epc = 1'b1; exc_req = 1'b1; issue("eret_exc", 0, 1, 0);

    // Reset on busy cycle 3 of a div
    step(); E_md_start = 1'b1; E_md_is_div = 1'b1; D_is_md = 1'b1; issue("rdiv_t0", 1, 0, 1);
    step(); D_is_md = 1'b1; issue("rdiv_b1", 1, 0, 1);
    step(); D_is_md = 1'b1; reset = 1'b1; issue("rdiv_rst", 0, 0, 0);
    step(); D_is_md = 1'b1; issue("rdiv_after", 0, 0, 0);
    step(); issue("rdiv_cnt0", 0, 0, 0);

    step();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS pipeline.
- Detects Tuse/Tnew data hazards, mult/div unit occupancy and eret-vs-mtc0 EPC hazards from D/E/M stage information.
- Drives the stall bubble into the E pipeline register, the enables of the F/D registers and the exception-flush request to all stage registers.
- Owns the mult/div busy counter FSM and a saturating stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu after issue in E.
- DIV_LAT, 10, busy cycles for div/divu after issue in E.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- D_rs  in  5  D-stage rs register number.
- D_rt  in  5  D-stage rt register number.
- D_tuse_rs  in  2  rs Tuse; 3 means not used.
- D_tuse_rt  in  2  rt Tuse; 3 means not used.
- D_is_md  in  1  D instruction uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
- D_eret  in  1  D instruction is eret.
- E_wa  in  5  E-stage destination register.
- E_tnew  in  2  E-stage Tnew.
- M_wa  in  5  M-stage destination register.
- M_tnew  in  2  M-stage Tnew.
- E_md_start  in  1  mult/div issuing in E this cycle.
- E_md_is_div  in  1  issuing op is div/divu.
- E_mtc0_epc  in  1  E instruction is mtc0 to EPC.
- M_mtc0_epc  in  1  M instruction is mtc0 to EPC.
- exc_req  in  1  CP0 exception/interrupt request.
- stall  out  1  to E register stall (bubble insert, pc/BD retained).
- en_F  out  1  PC register enable.
- en_D  out  1  D register enable.
- req  out  1  flush to D/E/M/W registers; PC loads handler.
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: md_state ∈ {IDLE, BUSY}; md_cnt 4 bits; stall_cnt.
- Reset: md_state=IDLE, md_cnt=0, stall_cnt=0.
- Outputs while reset is high: stall=0, en_F=1, en_D=1, req=0, md_busy=0.
- Data hazard, rs: stall_rs = (D_rs!=0) & ((E_wa==D_rs & E_tnew>D_tuse_rs) | (M_wa==D_rs & M_tnew>D_tuse_rs)). Compare unsigned. Tuse=3 never stalls.
- Data hazard, rt: identical with D_rt and D_tuse_rt.
- md_busy (combinational): (md_state==BUSY) | (E_md_start & ~exc_req).
- stall_md = D_is_md & md_busy.
- stall_eret = D_eret & (E_mtc0_epc | M_mtc0_epc).
- raw_stall = stall_rs | stall_rt | stall_md | stall_eret.
- Exception priority: exc_req overrides everything. req=exc_req, stall=raw_stall & ~exc_req, en_F=en_D=~stall. All outputs are combinational, zero latency.
- FSM IDLE: on E_md_start & ~exc_req, go to BUSY with md_cnt = (E_md_is_div ? DIV_LAT : MULT_LAT) - 1.
- FSM IDLE: E_md_start coincident with exc_req is suppressed; the instruction is flushed and the FSM stays IDLE.
- FSM BUSY: md_cnt decrements each cycle. When md_cnt==0, return to IDLE next cycle. Busy therefore lasts exactly LAT cycles including the issue cycle.
- FSM BUSY: exc_req does not abort; the issued op still completes its count.
- FSM BUSY: E_md_start cannot occur (D md instruction is held by stall_md). If asserted anyway, ignore it.
- stall_cnt increments on every cycle with stall=1. It holds at all-ones (saturates) and is not cleared by req.
- Reset mid-BUSY: immediate return to IDLE, md_cnt=0.

Test Plan:
- Load-use: E_wa=5, E_tnew=2, D_rs=5, D_tuse_rs=0 -> stall=1, en_F=en_D=0. Next cycle E_tnew=1, M_wa=5, M_tnew=1 -> stall=1. Then M_tnew=0 -> stall=0.
- $0 destination: E_wa=0, E_tnew=2, D_rs=0, D_tuse_rs=0 -> stall=0. Same pattern with D_tuse_rs=3 on any register -> stall=0.
- mult: E_md_start=1, is_div=0 at cycle t, D_is_md=1 thereafter -> md_busy=1 and stall=1 for cycles t..t+4, 0 at t+5. Repeat with div -> busy t..t+9. stall_cnt reaches 5 then 15.
- Exception vs start: E_md_start=1 with exc_req=1 -> req=1, stall=0, md_busy=0, FSM stays IDLE. exc_req during BUSY -> req=1, busy continues to full count.
- eret hazard: D_eret=1, E_mtc0_epc=1 -> stall=1. Then M_mtc0_epc=1 -> stall=1. Then neither -> stall=0. With exc_req=1 throughout -> stall=0, req=1.
- Reset at BUSY cycle 3 of a div -> next cycle md_busy=0, stall_cnt=0. Separately, preload stall_cnt to all-ones (CNT_W=4 instance) and hold stall -> remains 4'hF.
